// File: rtl/uart_rx_page_buffer.sv
// Circular byte buffer between the UART file receiver and the QSPI page-program engine.
// Bytes are captured while buff_wren is high and handed off one flash page at a time.
module uart_rx_page_buffer #(
  parameter int PAGE_BYTES = 256,
  parameter int DEPTH      = 4096,
  parameter int AW         = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          buff_wren,
  input  logic          i_Rx_DV,
  input  logic [7:0]    i_Rx_Byte,
  output logic          page_valid,
  output logic [8:0]    page_len,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rd_data_valid,
  input  logic          page_release,
  output logic [AW:0]   fill_cnt,
  output logic [15:0]   burst_cnt,
  output logic          overflow
);

  typedef enum logic [1:0] {IDLE, PAGE_RDY, READING, RELEASE} state_e;

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] PAGE_C  = (AW+1)'(PAGE_BYTES);

  state_e        state_q, state_d;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   fill_q, fill_d;
  logic [8:0]    page_len_q, page_len_d;
  logic [8:0]    rem_q, rem_d;
  logic [15:0]   burst_q, burst_d;
  logic          wren_q, flush_q, flush_d, ovf_q;
  logic [7:0]    rd_data_q;
  logic          rd_data_valid_q;
  logic          wr_req, wr_acc, rd_acc, wren_rise, wren_fall;

  assign wr_req    = buff_wren && i_Rx_DV;
  assign wr_acc    = wr_req && (fill_q != DEPTH_C);
  // The first pull in PAGE_RDY is a real read; it also moves the FSM to READING.
  assign rd_acc    = rd_en && (rem_q != '0) && ((state_q == PAGE_RDY) || (state_q == READING));
  assign wren_rise = buff_wren && !wren_q;
  assign wren_fall = !buff_wren && wren_q;

  always_comb begin
    fill_d = fill_q;
    if (wr_acc && !rd_acc)      fill_d = fill_q + 1'b1;
    else if (!wr_acc && rd_acc) fill_d = fill_q - 1'b1;
  end

  always_comb begin
    burst_d = burst_q;
    if (wren_rise)   burst_d = wr_acc ? 16'd1 : '0;
    else if (wr_acc) burst_d = burst_q + 16'd1;
  end

  always_comb begin
    flush_d = flush_q;
    if (wren_fall && (fill_q != '0)) flush_d = 1'b1;
    if (fill_d == '0)                flush_d = 1'b0;
  end

  always_comb begin
    state_d    = state_q;
    page_len_d = page_len_q;
    rem_d      = rd_acc ? rem_q - 9'd1 : rem_q;
    unique case (state_q)
      IDLE: begin
        if ((fill_q >= PAGE_C) || (flush_q && (fill_q != '0))) begin
          state_d    = PAGE_RDY;
          page_len_d = (fill_q >= PAGE_C) ? 9'(PAGE_BYTES) : fill_q[8:0];
          rem_d      = page_len_d;
        end
      end
      PAGE_RDY: if (rd_acc) state_d = READING;
      READING:  if ((rem_q == '0) && page_release) state_d = RELEASE;
      RELEASE:  state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      fill_q          <= '0;
      page_len_q      <= '0;
      rem_q           <= '0;
      burst_q         <= '0;
      wren_q          <= 1'b0;
      flush_q         <= 1'b0;
      ovf_q           <= 1'b0;
      rd_data_q       <= '0;
      rd_data_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      fill_q          <= fill_d;
      page_len_q      <= page_len_d;
      rem_q           <= rem_d;
      burst_q         <= burst_d;
      wren_q          <= buff_wren;
      flush_q         <= flush_d;
      rd_data_valid_q <= rd_acc;
      if (wr_req && !wr_acc) ovf_q <= 1'b1;
      if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_acc) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem[rd_ptr_q];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= i_Rx_Byte;
  end

  assign page_valid    = (state_q == PAGE_RDY) || (state_q == READING);
  assign page_len      = page_len_q;
  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_data_valid_q;
  assign fill_cnt      = fill_q;
  assign burst_cnt     = burst_q;
  assign overflow      = ovf_q;

endmodule
